fb_arbiter: RTL and testbench

- Owns the single-port, double-banked frame-buffer RAM that sits between the SPI pixel deserialiser (writer) and the HUB75 row-scan engine (reader). Both share one clock.
- Grants one RAM access per cycle. The reader has priority; a bounded-wait guard prevents the writer from starving.
- Performs front/back bank swap. It is requested by the writer at end of frame and committed only at a reader frame boundary, so the panel never shows a torn image.

---
 rtl/fb_arbiter.sv | 121 ++++++++++++
 tb/tb_fb_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_arbiter.sv
// Frame-buffer arbiter: shares one single-port, double-banked RAM between the
// SPI pixel writer and the HUB75 scan reader. Reader has priority, a wait
// counter bounds writer starvation, and bank swaps commit only on a reader
// frame boundary so the panel never shows a torn image.
module fb_arbiter #(
    parameter int unsigned ADDR_WIDTH  = 11,
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned WR_MAX_WAIT = 8
) (
    input  logic                  pixel_clk,
    input  logic                  n_reset,

    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ack,
    input  logic                  wr_frame_done,

    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_grant,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_frame_end,

    output logic [ADDR_WIDTH:0]   mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rdata,

    output logic                  front_bank,
    output logic                  swap_pending,
    output logic                  overrun
);

    localparam logic [7:0] WAIT_LIMIT = 8'(WR_MAX_WAIT);

    logic [7:0] wait_cnt;
    logic       wr_eligible;
    logic       wr_override;
    logic       grant_wr;
    logic       grant_rd;

    // Arbitration: starved writer first, then reader, then writer; nothing in reset.
    always_comb begin
        wr_eligible = wr_req & ~swap_pending;
        wr_override = wr_eligible & (wait_cnt >= WAIT_LIMIT);
        grant_wr    = 1'b0;
        grant_rd    = 1'b0;
        if (n_reset) begin
            if (wr_override) begin
                grant_wr = 1'b1;
            end else if (rd_req) begin
                grant_rd = 1'b1;
            end else if (wr_eligible) begin
                grant_wr = 1'b1;
            end
        end
    end

    // RAM address mux: writes go to the back bank, everything else points at the front bank.
    always_comb begin
        mem_addr = '0;
        if (n_reset) begin
            if (grant_wr) begin
                mem_addr = {~front_bank, wr_addr};
            end else begin
                mem_addr = {front_bank, rd_addr};
            end
        end
    end

    assign wr_ack    = grant_wr;
    assign rd_grant  = grant_rd;
    assign mem_we    = grant_wr;
    assign mem_wdata = wr_data;
    assign rd_data   = mem_rdata;

    // Writer starvation counter: counts consecutive denied cycles, saturating.
    always_ff @(posedge pixel_clk or negedge n_reset) begin
        if (!n_reset) begin
            wait_cnt <= '0;
        end else if (wr_eligible && !grant_wr) begin
            if (wait_cnt != '1) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end else begin
            wait_cnt <= '0;
        end
    end

    // Read data qualifier: RAM has one cycle of latency after a read grant.
    always_ff @(posedge pixel_clk or negedge n_reset) begin
        if (!n_reset) begin
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= grant_rd;
        end
    end

    // Bank swap: a pending swap commits at reader frame end; a frame_done seen
    // while already pending (including the commit edge itself) is an overrun.
    always_ff @(posedge pixel_clk or negedge n_reset) begin
        if (!n_reset) begin
            front_bank   <= 1'b0;
            swap_pending <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            overrun <= wr_frame_done & swap_pending;
            if (swap_pending) begin
                if (rd_frame_end) begin
                    front_bank   <= ~front_bank;
                    swap_pending <= 1'b0;
                end
            end else if (wr_frame_done) begin
                swap_pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fb_arbiter.sv
// Self-checking bench for fb_arbiter: a driver issues directed and random
// traffic and queues the expected per-cycle response from a frame-buffer
// reference model; a monitor pops and compares mid-cycle.
module tb_fb_arbiter;

    localparam int AW = 11;
    localparam int DW = 16;
    localparam int MW = 8;

    logic          pixel_clk = 1'b0;
    logic          n_reset;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ack;
    logic          wr_frame_done;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_grant;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          rd_frame_end;
    logic [AW:0]   mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;
    logic          front_bank;
    logic          swap_pending;
    logic          overrun;

    fb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WR_MAX_WAIT(MW)) dut (
        .pixel_clk(pixel_clk), .n_reset(n_reset),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .wr_frame_done(wr_frame_done),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_grant(rd_grant), .rd_valid(rd_valid),
        .rd_data(rd_data), .rd_frame_end(rd_frame_end),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .front_bank(front_bank), .swap_pending(swap_pending), .overrun(overrun)
    );

    always #5 pixel_clk = ~pixel_clk;

    typedef struct {
        logic          wr_ack;
        logic          rd_grant;
        logic          mem_we;
        logic [AW:0]   mem_addr;
        logic [DW-1:0] wdata;
        logic          front;
        logic          pend;
        logic          ovr;
        logic          rvalid;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] rd_q[$];
    logic [DW-1:0] ram  [0:4095];
    logic [DW-1:0] gold [0:4095];

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    logic m_front, m_pend, m_ovr, m_rv, last_gw, last_gr;
    int   m_streak;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Synchronous RAM: write-enable plus one-cycle read latency.
    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 16'((i * 37) ^ 16'h5a5a);
        ram[12'h010] = 16'h1230;
        mem_rdata = '0;
        forever begin
            @(posedge pixel_clk);
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= ram[mem_addr];
        end
    end

    // Monitor: mid-cycle comparison against queued expectations.
    exp_t mon_e;
    always @(negedge pixel_clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("wr_ack",       32'(wr_ack),       32'(mon_e.wr_ack));
            check("rd_grant",     32'(rd_grant),     32'(mon_e.rd_grant));
            check("mem_we",       32'(mem_we),       32'(mon_e.mem_we));
            check("mem_addr",     32'(mem_addr),     32'(mon_e.mem_addr));
            check("front_bank",   32'(front_bank),   32'(mon_e.front));
            check("swap_pending", 32'(swap_pending), 32'(mon_e.pend));
            check("overrun",      32'(overrun),      32'(mon_e.ovr));
            check("rd_valid",     32'(rd_valid),     32'(mon_e.rvalid));
            if (mon_e.mem_we) check("mem_wdata", 32'(mem_wdata), 32'(mon_e.wdata));
        end
        if (rd_valid === 1'b1) begin
            if (rd_q.size() == 0) check("rd_valid_spurious", 32'(rd_valid), 32'(0));
            else check("rd_data", 32'(rd_data), 32'(rd_q.pop_front()));
        end
    end

    // One cycle: drive inputs, predict the arbiter's response, advance the model.
    task automatic step(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic r, input logic [AW-1:0] ra,
                        input logic wfd, input logic rfe);
        exp_t e;
        logic welig, starved, gw, gr;
        wr_req = w; wr_addr = wa; wr_data = wd;
        rd_req = r; rd_addr = ra;
        wr_frame_done = wfd; rd_frame_end = rfe;
        welig   = w && !m_pend;
        starved = welig && (m_streak >= MW);
        gw      = starved || (welig && !r);
        gr      = r && !starved;
        e.wr_ack   = gw;
        e.rd_grant = gr;
        e.mem_we   = gw;
        e.mem_addr = gw ? {~m_front, wa} : {m_front, ra};
        e.wdata    = wd;
        e.front    = m_front;
        e.pend     = m_pend;
        e.ovr      = m_ovr;
        e.rvalid   = m_rv;
        exp_q.push_back(e);
        if (gr) rd_q.push_back(gold[{m_front, ra}]);
        if (gw) gold[{~m_front, wa}] = wd;
        m_streak = (welig && !gw) ? m_streak + 1 : 0;
        m_rv     = gr;
        m_ovr    = wfd && m_pend;
        if (m_pend && rfe) begin
            m_front = ~m_front;
            m_pend  = 1'b0;
        end else if (!m_pend && wfd) begin
            m_pend = 1'b1;
        end
        last_gw = gw;
        last_gr = gr;
        @(posedge pixel_clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic model_reset();
        m_front = 1'b0; m_pend = 1'b0; m_ovr = 1'b0; m_rv = 1'b0; m_streak = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wr_ack"},   32'(wr_ack),       32'(0));
        check({tag, "_rd_grant"}, 32'(rd_grant),     32'(0));
        check({tag, "_mem_we"},   32'(mem_we),       32'(0));
        check({tag, "_mem_addr"}, 32'(mem_addr),     32'(0));
        check({tag, "_front"},    32'(front_bank),   32'(0));
        check({tag, "_pending"},  32'(swap_pending), 32'(0));
        check({tag, "_rd_valid"}, 32'(rd_valid),     32'(0));
        check({tag, "_overrun"},  32'(overrun),      32'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic          w_act, r_act, wfd, rfe;
        logic [AW-1:0] wa, ra;
        logic [DW-1:0] wd;
        int            guard;

        for (int i = 0; i < 4096; i++) gold[i] = 16'((i * 37) ^ 16'h5a5a);
        gold[12'h010] = 16'h1230;
        model_reset();

        // Reset with both requesters active: all grants must stay low.
        n_reset = 1'b0;
        wr_req = 1'b1; wr_addr = 11'h005; wr_data = 16'hABC0;
        rd_req = 1'b1; rd_addr = 11'h010;
        wr_frame_done = 1'b0; rd_frame_end = 1'b0;
        #3;
        check_reset_outputs("reset");
        repeat (2) @(posedge pixel_clk);
        #1;
        n_reset = 1'b1;

        // Lone write goes to back bank 1.
        step(1'b1, 11'h005, 16'hABC0, 1'b0, '0, 1'b0, 1'b0);
        // Continuous contention: reader 8 cycles, writer on the 9th.
        for (int i = 0; i < 27; i++) step(1'b1, 11'h020, 16'h5555, 1'b1, 11'h030, 1'b0, 1'b0);
        idle();
        // Preloaded read from bank 0.
        step(1'b0, '0, '0, 1'b1, 11'h010, 1'b0, 1'b0);
        idle();
        // Frame done blocks writes until reader frame end swaps banks.
        step(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 11'h040, 16'h7777, 1'b0, '0, 1'b0, 1'b0);
        step(1'b1, 11'h040, 16'h7777, 1'b0, '0, 1'b0, 1'b1);
        step(1'b1, 11'h040, 16'h7777, 1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 11'h040, 1'b0, 1'b0);
        idle();
        // Simultaneous frame done and frame end with nothing pending: no swap yet.
        step(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b1);
        idle();
        idle();
        step(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b1);
        idle();
        // Overrun: second frame done while pending.
        step(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0);
        idle();
        // Commit edge coinciding with a new frame done.
        step(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b1);
        idle();
        idle();

        // Randomised traffic with handshake-respecting requesters.
        w_act = 1'b0; r_act = 1'b0; wa = '0; ra = '0; wd = '0;
        for (int n = 0; n < 1500; n++) begin
            if (!w_act) begin
                w_act = ($urandom_range(0, 9) < 6);
                wa    = AW'($urandom);
                wd    = DW'($urandom);
            end
            if (!r_act) begin
                r_act = ($urandom_range(0, 9) < 7);
                ra    = AW'($urandom);
            end
            wfd = ($urandom_range(0, 39) == 0);
            rfe = ($urandom_range(0, 29) == 0);
            step(w_act, wa, wd, r_act, ra, wfd, rfe);
            if (last_gw) w_act = 1'b0;
            if (last_gr) r_act = 1'b0;
        end
        idle();
        idle();

        // Reach front_bank=1 with a swap pending, then reset during a read.
        guard = 0;
        while (!(m_front && m_pend) && guard < 8) begin
            if (!m_pend) step(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0);
            else         step(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b1);
            guard++;
        end
        check("reset_setup", 32'({m_front, m_pend}), 32'(2'b11));
        step(1'b0, '0, '0, 1'b1, 11'h123, 1'b0, 1'b0);
        wr_req = 1'b1; rd_req = 1'b1;
        check("pre_reset_rd_valid", 32'(rd_valid), 32'(1));
        #1;
        n_reset = 1'b0;
        #1;
        check_reset_outputs("midreset");
        rd_q.delete();
        @(posedge pixel_clk);
        #1;
        check_reset_outputs("heldreset");
        n_reset = 1'b1;
        model_reset();
        step(1'b1, 11'h077, 16'hBEEF, 1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 11'h077, 1'b0, 1'b0);
        idle();
        idle();

        @(negedge pixel_clk);
        #1;
        check("exp_q_drained", 32'(exp_q.size()), 32'(0));
        check("rd_q_drained",  32'(rd_q.size()),  32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
